// File: rtl/cnn_pkg.sv
// Purpose: shared widths, host write-select encodings and loader FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cnn_pkg;

    localparam int IMG_W    = 4;
    localparam int F1_W     = 4;
    localparam int F2_W     = 10;
    localparam int RES_W    = 22;
    localparam int WR_DAT_W = 10;

    // Host write target selection.
    typedef enum logic [1:0] {
        SEL_IMG = 2'd0,
        SEL_F1  = 2'd1,
        SEL_F2  = 2'd2,
        SEL_NOP = 2'd3
    } wr_sel_e;

    // Playback sequence, in the order the CNN input protocol requires.
    typedef enum logic [2:0] {
        IDLE,
        L1_STREAM,
        L1_TAIL,
        L1_READ,
        L2_STREAM,
        L2_TAIL,
        L2_READ,
        DONE
    } state_e;

endpackage

// File: rtl/cnn_stream_loader_if.sv
// Purpose: host write port, go strobe and the CNN-facing stimulus/result bus.
// Latency: n/a (wiring only).
// Backpressure: none; the loader owns the timing of every CNN-facing signal.
interface cnn_stream_loader_if #(
    parameter int ADDR_W = 4
);
    import cnn_pkg::*;

    // Host side
    logic                wr_en;
    logic [1:0]          wr_sel;
    logic [ADDR_W-1:0]   wr_addr;
    logic [WR_DAT_W-1:0] wr_data;
    logic                go;
    logic                busy;
    logic                done;
    logic [RES_W-1:0]    result_q;

    // CNN side
    logic [RES_W-1:0]    ConvResult;
    logic                Start1;
    logic [IMG_W-1:0]    Image;
    logic [F1_W-1:0]     Filter1;
    logic                ReadEn1;
    logic                Start2;
    logic [F2_W-1:0]     Filter2;
    logic                ReadEn2;

    // The loader drives the CNN inputs and the host status.
    modport master (
        input  wr_en, wr_sel, wr_addr, wr_data, go, ConvResult,
        output Start1, Image, Filter1, ReadEn1, Start2, Filter2, ReadEn2,
        output busy, done, result_q
    );

    // Host plus CNN, seen from outside the loader.
    modport slave (
        output wr_en, wr_sel, wr_addr, wr_data, go, ConvResult,
        input  Start1, Image, Filter1, ReadEn1, Start2, Filter2, ReadEn2,
        input  busy, done, result_q
    );

endinterface

// File: rtl/cnn_operand_mem.sv
// Purpose: operand register file, one write port, combinational read.
// Latency: write visible to the read port one cycle after the write edge.
// Backpressure: none; writes at index >= DEPTH are silently dropped.
module cnn_operand_mem #(
    parameter int W     = 4,
    parameter int DEPTH = 15,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    // Sized to the full address space so the read index needs no narrowing;
    // entries at DEPTH and above are never written nor read.
    logic [W-1:0] mem [2**AW];
    logic         in_range;

    assign in_range = (int'(waddr) < DEPTH);
    assign rdata    = mem[raddr];

    // Store host data; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/cnn_stream_loader.sv
// Purpose: replays preloaded L1/L2 operands into the CNN and captures ConvResult.
// Latency: done is high L1_LEN+GAP+L2_LEN+RD2_WAIT+3 cycles after the go edge.
// Backpressure: none; go and host writes are ignored while busy.
module cnn_stream_loader
    import cnn_pkg::*;
#(
    parameter int L1_LEN   = 15,
    parameter int L2_LEN   = 15,
    parameter int ADDR_W   = 4,
    parameter int GAP      = 2,
    parameter int RD2_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    cnn_stream_loader_if.master bus
);

    localparam int WAIT_MAX = (GAP > RD2_WAIT) ? GAP : RD2_WAIT;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;

    logic                idle;
    logic                we_img, we_f1, we_f2;
    logic [IMG_W-1:0]    img_rd;
    logic [F1_W-1:0]     f1_rd;
    logic [F2_W-1:0]     f2_rd;

    assign idle   = (state_q == IDLE);
    assign we_img = bus.wr_en && idle && (bus.wr_sel == SEL_IMG);
    assign we_f1  = bus.wr_en && idle && (bus.wr_sel == SEL_F1);
    assign we_f2  = bus.wr_en && idle && (bus.wr_sel == SEL_F2);

    cnn_operand_mem #(.W(IMG_W), .DEPTH(L1_LEN), .AW(ADDR_W)) u_img_mem (
        .clk   (clk),
        .we    (we_img),
        .waddr (bus.wr_addr),
        .wdata (bus.wr_data[IMG_W-1:0]),
        .raddr (idx_q),
        .rdata (img_rd)
    );

    cnn_operand_mem #(.W(F1_W), .DEPTH(L1_LEN), .AW(ADDR_W)) u_f1_mem (
        .clk   (clk),
        .we    (we_f1),
        .waddr (bus.wr_addr),
        .wdata (bus.wr_data[F1_W-1:0]),
        .raddr (idx_q),
        .rdata (f1_rd)
    );

    cnn_operand_mem #(.W(F2_W), .DEPTH(L2_LEN), .AW(ADDR_W)) u_f2_mem (
        .clk   (clk),
        .we    (we_f2),
        .waddr (bus.wr_addr),
        .wdata (bus.wr_data[F2_W-1:0]),
        .raddr (idx_q),
        .rdata (f2_rd)
    );

    // State and counter registers; rst wins over everything, mid-stream included.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state sequencing; idx walks the operand streams, wait times the read holds.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        unique case (state_q)
            IDLE: begin
                if (bus.go) begin
                    state_d = L1_STREAM;
                    idx_d   = '0;
                end
            end
            L1_STREAM: begin
                if (idx_q == ADDR_W'(L1_LEN - 1)) begin
                    state_d = L1_TAIL;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            L1_TAIL: begin
                state_d = L1_READ;
                wait_d  = '0;
            end
            L1_READ: begin
                if (wait_q == WAIT_W'(GAP - 1)) begin
                    state_d = L2_STREAM;
                    idx_d   = '0;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            L2_STREAM: begin
                if (idx_q == ADDR_W'(L2_LEN - 1)) begin
                    state_d = L2_TAIL;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            L2_TAIL: begin
                state_d = L2_READ;
                wait_d  = '0;
            end
            L2_READ: begin
                if (wait_q == WAIT_W'(RD2_WAIT - 1)) begin
                    state_d = DONE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs trail the state by one cycle; operands are zeroed outside their frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.Start1   <= 1'b0;
            bus.Image    <= '0;
            bus.Filter1  <= '0;
            bus.ReadEn1  <= 1'b0;
            bus.Start2   <= 1'b0;
            bus.Filter2  <= '0;
            bus.ReadEn2  <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.result_q <= '0;
        end else begin
            bus.Start1  <= (state_q == L1_STREAM);
            bus.Image   <= (state_q == L1_STREAM) ? img_rd : '0;
            bus.Filter1 <= (state_q == L1_STREAM) ? f1_rd  : '0;
            bus.ReadEn1 <= (state_q inside {L1_READ, L2_STREAM, L2_TAIL, L2_READ, DONE});
            bus.Start2  <= (state_q == L2_STREAM);
            bus.Filter2 <= (state_q == L2_STREAM) ? f2_rd  : '0;
            bus.ReadEn2 <= (state_q == L2_READ);
            bus.busy    <= (state_q != IDLE);
            bus.done    <= (state_q == DONE);
            // ConvResult as seen during the last ReadEn2 cycle.
            if (state_q == DONE) begin
                bus.result_q <= bus.ConvResult;
            end
        end
    end

endmodule
